// File: rtl/ctrl_sequencer.sv
// Step-strobe generator for the multi-cycle CPU: fetch T0..T2, per-opcode execute length,
// memory wait/timeout and Stop/Resume run control. Define INT_EN to add IntReq/IntAck interrupt entry.
module ctrl_sequencer #(
    parameter int IR_W       = 32,
    parameter int OPC_MSB    = 31,
    parameter int STEP_N     = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IR_W-1:0]   IR,
    input  logic              MemReady,
    input  logic              Stop,
    input  logic              Resume,
`ifdef INT_EN
    input  logic              IntReq,
    output logic              IntAck,
`endif
    output logic [STEP_N-1:0] Step,
    output logic              Run,
    output logic              MemRd,
    output logic              MemWr,
    output logic              InstrDone,
    output logic              IllegalOp,
    output logic              BusErr
);
    localparam int SW  = $clog2(STEP_N);
    localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

`ifdef INT_EN
    typedef enum logic [2:0] {S_RESET, S_STEP, S_HALTED, S_INT0, S_INT1} state_t;
`else
    typedef enum logic [1:0] {S_RESET, S_STEP, S_HALTED} state_t;
`endif

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [WCW-1:0] wait_q, wait_d;

    logic [4:0]     opc;
    logic [SW-1:0]  last_idx;
    logic           unused_ir;
    logic           mem_rd_step, mem_wr_step, in_mem, timeout, hold, done;

    // Index of the final execute step: T(2+LEN).
    function automatic logic [SW-1:0] last_step(input logic [4:0] op);
        logic [2:0] len;
        if (op == 5'd0 || op == 5'd2)                        len = 3'd5;
        else if (op == 5'd14 || op == 5'd15 || op == 5'd18) len = 3'd4;
        else if (op >= 5'd1 && op <= 5'd13)                 len = 3'd3;
        else if (op == 5'd16 || op == 5'd17 || op == 5'd20) len = 3'd2;
        else                                                len = 3'd1;
        return SW'({2'b00, len} + 5'd2);
    endfunction

    assign opc       = IR[OPC_MSB -: 5];
    assign unused_ir = ^IR;
    assign last_idx  = last_step(opc);

    assign mem_rd_step = (step_q == SW'(1)) || (opc == 5'd0 && step_q == SW'(6));
    assign mem_wr_step = (opc == 5'd2) && (step_q == SW'(7));
    assign in_mem      = (state_q == S_STEP) && (mem_rd_step || mem_wr_step);
    assign timeout     = in_mem && !MemReady && (WAIT_LIMIT > 0) && (wait_q == WCW'(WAIT_LIMIT));
    assign hold        = in_mem && !MemReady && !timeout;
    // A stalled final memory step only counts as done on the cycle it completes.
    assign done        = (state_q == S_STEP) && (step_q == last_idx) && !hold && !timeout;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_RESET;
            step_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        wait_d    = '0;
        Step      = '0;
        Run       = 1'b0;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        BusErr    = 1'b0;
`ifdef INT_EN
        IntAck    = 1'b0;
`endif
        unique case (state_q)
            S_RESET: begin
                state_d = S_STEP;
                step_d  = '0;
            end
            S_STEP: begin
                Run       = 1'b1;
                Step      = STEP_N'(1) << step_q;
                MemRd     = mem_rd_step && !timeout;
                MemWr     = mem_wr_step && !timeout;
                BusErr    = timeout;
                InstrDone = done;
                IllegalOp = (step_q == SW'(3)) && (opc >= 5'd27);
                if (timeout) begin
                    step_d = '0;
                end else if (hold) begin
                    wait_d = (WAIT_LIMIT > 0) ? wait_q + WCW'(1) : '0;
                end else if (done) begin
                    step_d = '0;
                    // Stop outranks an interrupt request, which stays pending.
                    if (opc == 5'd26 || Stop) state_d = S_HALTED;
`ifdef INT_EN
                    else if (IntReq)          state_d = S_INT0;
`endif
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_HALTED: begin
`ifdef INT_EN
                if (IntReq) begin
                    state_d = S_INT0;
                end else
`endif
                if (Resume && !Stop) begin
                    state_d = S_STEP;
                    step_d  = '0;
                end
            end
`ifdef INT_EN
            S_INT0: begin
                Run     = 1'b1;
                state_d = S_INT1;
            end
            S_INT1: begin
                Run     = 1'b1;
                IntAck  = 1'b1;
                state_d = S_STEP;
                step_d  = '0;
            end
`endif
            default: begin
                state_d = S_RESET;
            end
        endcase
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: instruction-level trace model versus cycle outputs.
module tb_ctrl_sequencer;
    localparam int STEP_N     = 8;
    localparam int WAIT_LIMIT = 15;

    logic              Clock = 1'b0;
    logic              Reset, MemReady, Stop, Resume;
    logic [31:0]       IR;
    logic [STEP_N-1:0] Step;
    logic              Run, MemRd, MemWr, InstrDone, IllegalOp, BusErr;
`ifdef INT_EN
    logic              IntReq, IntAck;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int step;
        bit rdy, stp, res, run, rd, wr, done, ill, berr;
    } rec_t;
    rec_t exp_q[$];

    ctrl_sequencer #(.IR_W(32), .OPC_MSB(31), .STEP_N(STEP_N), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MemReady(MemReady), .Stop(Stop), .Resume(Resume),
`ifdef INT_EN
        .IntReq(IntReq), .IntAck(IntAck),
`endif
        .Step(Step), .Run(Run), .MemRd(MemRd), .MemWr(MemWr),
        .InstrDone(InstrDone), .IllegalOp(IllegalOp), .BusErr(BusErr)
    );

    always #5 Clock = ~Clock;

    function automatic int len_of(int op);
        if (op == 0 || op == 2) return 5;
        if (op == 14 || op == 15 || op == 18) return 4;
        if (op >= 1 && op <= 13) return 3;
        if (op == 16 || op == 17 || op == 20) return 2;
        return 1;
    endfunction

    function automatic rec_t mk(int step, bit rdy, bit stp);
        rec_t r;
        r.step = step; r.rdy = rdy; r.stp = stp; r.res = 1'b0; r.run = 1'b1;
        r.rd = 1'b0; r.wr = 1'b0; r.done = 1'b0; r.ill = 1'b0; r.berr = 1'b0;
        return r;
    endfunction

    function automatic rec_t mkh(bit stp, bit res);
        rec_t r = mk(-1, 1'b0, stp);
        r.run = 1'b0;
        r.res = res;
        return r;
    endfunction

    // Memory step lasting 'waits' not-ready cycles; returns 1 when it ends in a timeout.
    function automatic bit push_mem(int step, int waits, bit rd, bit last, bit stp);
        bit   tmo = (WAIT_LIMIT > 0) && (waits >= WAIT_LIMIT);
        int   n   = tmo ? WAIT_LIMIT : waits;
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = mk(step, 1'b0, stp); r.rd = rd; r.wr = !rd;
            exp_q.push_back(r);
        end
        if (tmo) begin
            r = mk(step, 1'b0, stp); r.berr = 1'b1;
            exp_q.push_back(r);
            return 1'b1;
        end
        r = mk(step, 1'b1, stp); r.rd = rd; r.wr = !rd; r.done = last;
        exp_q.push_back(r);
        return 1'b0;
    endfunction

    // Expected cycle trace of one instruction from T0. Returns 0: T0 next, 1: halted, 2: aborted.
    function automatic int build(int op, int w1, int wm, bit stp);
        int last;
        bit mem;
        exp_q.delete();
        exp_q.push_back(mk(0, 1'b1, 1'b0));
        if (push_mem(1, w1, 1'b1, 1'b0, stp)) return 2;
        exp_q.push_back(mk(2, 1'($urandom_range(0, 1)), stp));
        last = 2 + len_of(op);
        for (int k = 3; k <= last; k++) begin
            mem = (op == 0 && k == 6) || (op == 2 && k == 7);
            if (mem) begin
                if (push_mem(k, wm, op == 0, k == last, stp)) return 2;
            end else begin
                rec_t r = mk(k, 1'($urandom_range(0, 1)), stp);
                r.ill  = (k == 3) && (op >= 27);
                r.done = (k == last);
                exp_q.push_back(r);
            end
        end
        return (op == 26 || stp) ? 1 : 0;
    endfunction

    function automatic logic [13:0] exp_vec(rec_t r);
        logic [7:0] s = 8'd0;
        if (r.step >= 0) s = 8'd1 << r.step;
        return {s, r.run, r.rd, r.wr, r.done, r.ill, r.berr};
    endfunction

    // Applies one cycle of inputs and returns the outputs sampled mid-cycle.
    task automatic step_cycle(input rec_t r, output logic [13:0] obs);
        MemReady = r.rdy;
        Stop     = r.stp;
        Resume   = r.res;
        @(negedge Clock);
        obs = {Step, Run, MemRd, MemWr, InstrDone, IllegalOp, BusErr};
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        Reset = 1'b0; IR = {5'd3, 27'($urandom)}; MemReady = 1'b1; Stop = 1'b0; Resume = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            obs = {Step, Run, MemRd, MemWr, InstrDone, IllegalOp, BusErr};
            checks++;
            if (obs !== 14'd0) begin
                failures++; $display("FAIL reset_low got=%b exp=%b", obs, 14'd0);
            end
            @(posedge Clock);
            #1;
        end
        Reset = 1'b1;
        step_cycle(mkh(1'b0, 1'b0), obs);
        checks++;
        if (obs !== 14'd0) begin
            failures++; $display("FAIL reset_state got=%b exp=%b", obs, 14'd0);
        end
    endtask

    task automatic test_add();
        logic [13:0] obs;
        void'(build(3, 0, 0, 1'b0));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL add_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
    endtask

    task automatic test_ld_wait();
        logic [13:0] obs;
        int t6 = 0;
        IR = {5'd0, 27'($urandom)};
        void'(build(0, 0, 4, 1'b0));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            if (obs[12] && obs[4]) t6++;
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL ld_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
        checks++;
        if (t6 !== 5) begin
            failures++; $display("FAIL ld_t6_hold got=%0d exp=%0d", t6, 5);
        end
    endtask

    task automatic test_st_timeout();
        logic [13:0] obs;
        int berr_n = 0;
        IR = {5'd2, 27'($urandom)};
        void'(build(2, 0, 100, 1'b0));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            berr_n += int'(obs[0]);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL st_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
        checks++;
        if (berr_n !== 1) begin
            failures++; $display("FAIL st_buserr_count got=%0d exp=%0d", berr_n, 1);
        end
    endtask

    task automatic test_halt_resume();
        logic [13:0] obs;
        IR = {5'd26, 27'($urandom)};
        void'(build(26, 1, 0, 1'b0));
        exp_q.push_back(mkh(1'b0, 1'b0));
        exp_q.push_back(mkh(1'b1, 1'b1));
        exp_q.push_back(mkh(1'b0, 1'b1));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL halt_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
    endtask

    task automatic test_illegal();
        logic [13:0] obs;
        IR = {5'd29, 27'($urandom)};
        void'(build(29, 0, 0, 1'b0));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL illegal_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
    endtask

    task automatic test_stop_mul();
        logic [13:0] obs;
        IR = {5'd14, 27'($urandom)};
        void'(build(14, 2, 0, 1'b1));
        exp_q.push_back(mkh(1'b0, 1'b1));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL stop_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] obs;
        IR = {5'd0, 27'($urandom)};
        void'(build(0, 0, 0, 1'b0));
        for (int i = 0; i < 4; i++) step_cycle(exp_q[i], obs);
        #2;
        Reset = 1'b0;
        #1;
        obs = {Step, Run, MemRd, MemWr, InstrDone, IllegalOp, BusErr};
        checks++;
        if (obs !== 14'd0) begin
            failures++; $display("FAIL reset_mid got=%b exp=%b", obs, 14'd0);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(mkh(1'b0, 1'b0));
        exp_q.push_back(mk(0, 1'b1, 1'b0));
        foreach (exp_q[i]) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL reset_restart cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
        // Now one cycle into T1 of a fresh fetch; finish this instruction.
        void'(build(0, 0, 0, 1'b0));
        for (int i = 1; i < exp_q.size(); i++) begin
            step_cycle(exp_q[i], obs);
            checks++;
            if (obs !== exp_vec(exp_q[i])) begin
                failures++; $display("FAIL reset_finish cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] obs;
        int op, w1, wm, res;
        bit stp;
        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 31);
            w1  = ($urandom_range(0, 9) == 0) ? WAIT_LIMIT : $urandom_range(0, 2);
            wm  = ($urandom_range(0, 5) == 0) ? $urandom_range(WAIT_LIMIT - 1, WAIT_LIMIT + 3)
                                              : $urandom_range(0, 3);
            stp = ($urandom_range(0, 5) == 0);
            IR  = {5'(op), 27'($urandom)};
            res = build(op, w1, wm, stp);
            if (res == 1) exp_q.push_back(mkh(1'b0, 1'b1));
            foreach (exp_q[i]) begin
                step_cycle(exp_q[i], obs);
                checks++;
                if (obs !== exp_vec(exp_q[i])) begin
                    failures++;
                    $display("FAIL random op=%0d cyc=%0d got=%b exp=%b", op, i, obs, exp_vec(exp_q[i]));
                end
            end
        end
    endtask

`ifdef INT_EN
    task automatic test_int();
        logic [13:0] obs;
        for (int pass = 0; pass < 2; pass++) begin
            IR = {5'd16, 27'($urandom)};
            void'(build(16, 0, 0, pass == 1));
            foreach (exp_q[i]) begin
                IntReq = (exp_q[i].step == 4);
                step_cycle(exp_q[i], obs);
                checks++;
                if (obs !== exp_vec(exp_q[i])) begin
                    failures++; $display("FAIL int_trace cyc=%0d got=%b exp=%b", i, obs, exp_vec(exp_q[i]));
                end
            end
            if (pass == 1) begin
                Stop = 1'b0;
                @(negedge Clock);
                checks++;
                if ({Step, Run, IntAck} !== 10'd0) begin
                    failures++; $display("FAIL int_halted got=%b exp=%b", {Step, Run, IntAck}, 10'd0);
                end
                @(posedge Clock);
                #1;
            end
            IntReq = 1'b0;
            @(negedge Clock);
            checks++;
            if ({Step, Run, IntAck} !== 10'b0000_0000_10) begin
                failures++; $display("FAIL int0 got=%b exp=%b", {Step, Run, IntAck}, 10'b0000_0000_10);
            end
            @(posedge Clock);
            #1;
            @(negedge Clock);
            checks++;
            if ({Step, Run, IntAck} !== 10'b0000_0000_11) begin
                failures++; $display("FAIL int1 got=%b exp=%b", {Step, Run, IntAck}, 10'b0000_0000_11);
            end
            @(posedge Clock);
            #1;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; IR = '0; MemReady = 1'b0; Stop = 1'b0; Resume = 1'b0;
`ifdef INT_EN
        IntReq = 1'b0;
`endif
        test_reset();
        test_add();
        test_ld_wait();
        test_st_timeout();
        test_halt_resume();
        test_illegal();
        test_stop_mul();
        test_reset_mid();
        test_random();
`ifdef INT_EN
        test_int();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised timing/step generator for the multi-cycle CPU datapath.
- Replaces the hard-coded per-opcode state list with fetch states, a generic execute step counter, a per-opcode step-length table, memory wait-state handshake with timeout, and Stop/Resume run control.
- Emits one-hot step strobes T0..T(STEP_N-1); the separate combinational control-signal decoder consumes them.

Parameters:
- IR_W, 32: instruction register width.
- OPC_MSB, 31: MSB of the 5-bit opcode field; opcode = IR[OPC_MSB:OPC_MSB-4].
- STEP_N, 8: number of step strobes; must be >= 8 (fixed longest instruction ends at T7).
- WAIT_LIMIT, 15: max cycles to wait for MemReady in a memory step; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IR  in  IR_W  instruction register contents; valid from T3 until the instruction ends.
- MemReady  in  1  memory completion, sampled on the rising edge.
- Stop  in  1  level; halts at the next instruction boundary.
- Resume  in  1  level; leaves HALTED.
- Step  out  STEP_N  one-hot step strobe; Step[k]=1 during Tk.
- Run  out  1  1 in every state except RESET and HALTED.
- MemRd  out  1  read request, asserted in T1 and in ld T6.
- MemWr  out  1  write request, asserted in st T7.
- InstrDone  out  1  1 during the last execute step.
- IllegalOp  out  1  1 during T3 when the opcode is unassigned.
- BusErr  out  1  one-cycle pulse on a memory timeout.

Behaviour:
- Reset low (asynchronous): state RESET; every output 0 and the wait counter cleared. Reset asserted mid-instruction aborts it immediately with no completion.
- RESET -> T0 on the first edge after Reset is released.
- Fetch: T0 (PC->MAR) -> T1 (MemRd=1; hold in T1 while MemReady=0) -> T2 (IR load) -> T3.
- Execute runs T3..T(2+LEN), one step per cycle except in memory steps. Opcode is decoded combinationally from IR during execute.
- LEN by opcode:
  - 0 ld: 5
  - 2 st: 5
  - 1 ldi: 3
  - 3..13 (ALU reg/imm): 3
  - 14 mul, 15 div: 4
  - 16 neg, 17 not: 2
  - 18 branch: 4
  - 20 jal: 2
  - 19, 21..24 (jr, in, out, mfhi, mflo): 1
  - 25 nop: 1
  - 26 halt: 1
  - 27..31 (illegal): 1, with IllegalOp=1 in T3; otherwise executed as nop.
- Memory steps: ld T6 (MemRd=1) and st T7 (MemWr=1).
  - Step holds while MemReady=0 and advances on the edge where MemReady=1.
  - The wait counter clears on entering any memory step, including T1.
- Timeout (WAIT_LIMIT>0): if the wait counter reaches WAIT_LIMIT with MemReady still 0:
  - BusErr=1 for one cycle, MemRd/MemWr dropped the same cycle, state -> T0.
  - The instruction is abandoned and InstrDone is not pulsed.
- Last execute step (InstrDone=1), next state:
  - opcode halt, or Stop=1 -> HALTED.
  - otherwise -> T0.
- HALTED: Step=0, Run=0. Resume=1 -> T0. If Stop and Resume are both 1, stay HALTED (Stop wins).
- Stop is sampled only at the last execute step. Stop asserted during fetch lets the current instruction complete.
- Step is strictly one-hot in T0..T(STEP_N-1) and all-zero in RESET, HALTED and INT states. Unused high step indices never assert.
- No combinational path from IR to the state register other than the LEN decode.

Optional Feature:
- Macro INT_EN. When defined, adds ports IntReq (in, 1, level) and IntAck (out, 1).
- At the last execute step with Stop=0 and IntReq=1, the sequencer enters INT0 -> INT1 -> T0 instead of T0.
  - IntAck=1 during INT1 only; Step=0 in both INT states.
  - In HALTED, IntReq=1 -> INT0 (wakes the core).
- Stop has priority over IntReq at a boundary; the request stays pending.
- When undefined: ports absent, INT states absent, behaviour exactly as above.

Test Plan:
- Reset low for 3 cycles, then high, with IR=add (opcode 3) and MemReady tied 1 -> Step walks T0,T1,T2,T3,T4,T5 then T0; InstrDone=1 only in T5; all outputs 0 while reset is low.
- ld (opcode 0), MemReady low for 4 cycles in T6 -> T6 held 5 cycles with MemRd=1; T7 follows; 12 cycles total T0..T7.
- st (opcode 2), MemReady stuck 0 in T7, WAIT_LIMIT=15 -> BusErr pulse after 15 wait cycles; MemWr drops that cycle; next state T0; no InstrDone.
- Opcode 26 (halt) -> T3 then HALTED with Run=0 and Step=0; Resume pulse -> T0. Opcode 29 -> IllegalOp=1 in T3, then T0.
- Stop raised during T1 of a mul (opcode 14) -> T3..T6 complete, then HALTED. Reset pulled low mid-T4 of a ld -> immediate RESET with all outputs 0.
- With INT_EN, IntReq=1 during neg (opcode 16) T4 -> INT0, INT1 (IntAck=1), T0. Stop=1 and IntReq=1 together -> HALTED, then wake via INT0.
